i2c_wb_slave_port: RTL and testbench
====================================

Name: i2c_wb_slave_port

Overview:
- Synthesizable I2C slave responder with a Wishbone classic slave register port.
- Sits on one I2C bus segment and answers a bus master, such as the multi-bus controller on bus 1.
- The local host reads bytes written by the I2C master and preloads bytes that the I2C master reads back.
- Byte buffering uses RX and TX FIFOs.

Parameters:
- I2C_ADDR, 7'h22, reset value of the slave-address register
- FIFO_DEPTH, 16, entries per RX and TX FIFO (power of two)
- WB_ADDR, 2, Wishbone address width
- WB_DATA, 8, Wishbone data width

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset
- cyc_i  in  1  Wishbone cycle valid
- stb_i  in  1  Wishbone strobe
- we_i  in  1  write enable
- adr_i  in  WB_ADDR  register select
- dat_i  in  WB_DATA  write data
- dat_o  out  WB_DATA  read data
- ack_o  out  1  Wishbone acknowledge
- irq  out  1  interrupt request
- scl_i  in  1  I2C clock (input only, no stretching)
- sda_i  in  1  I2C data in
- sda_o  out  1  open-drain data out: 0 pulls low, 1 releases

Interface: one clock, clk_i; reset rst_i is asynchronous and active-high.

Behaviour:
- Reset values: ack_o=0, dat_o=0, irq=0, sda_o=1, FIFOs empty, FSM IDLE, ADDR=I2C_ADDR, CSR=0.
- Wishbone timing:
  - ack_o pulses one cycle, starting the cycle after cyc_i&stb_i&!ack_o.
  - dat_o is valid during ack; writes take effect at ack.
- Register 0, CSR:
  - b7 EN (rw)
  - b6 IE (rw)
  - b4 STOP_SEEN (write 1 to clear)
  - b3 LAST_RD (ro, last transfer was a read)
  - b2 BUSY (ro, between START and STOP)
  - b1 TX_EMPTY (ro)
  - b0 RX_NONEMPTY (ro)
- Register 1, ADDR: b6:0 slave address.
- Register 2, RXDATA: read pops the RX FIFO; a read when empty returns 0x00 with no pop.
- Register 3, TXDATA: write pushes the TX FIFO; a write when full is dropped.
- irq = IE & (RX_NONEMPTY | STOP_SEEN), registered.
- Synchronizers: scl_i and sda_i pass through 2-flop synchronizers; edges are detected on the synchronized values.
- START = sda falling while scl high; STOP = sda rising while scl high. Both are detected only when EN=1.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- A START in any state (repeated start included) clears the bit counter and enters ADDR.
- A STOP in any state enters IDLE, sets STOP_SEEN and releases sda_o.
- Bits are sampled on scl rising edge, MSB first. The slave changes sda_o only on scl falling edge.
- ADDR:
  - After 8 bits, compare b7:1 with ADDR.
  - Match: drive ACK low for the 9th clock. R/W=0 goes to WR_DATA; R/W=1 pops TX and goes to RD_DATA.
  - Mismatch: go to WAIT_STOP, sda released.
- WR_DATA:
  - After 8 bits, push to RX and ACK, unless RX is full: then NACK (sda released), discard the byte, and go to WAIT_STOP.
- RD_DATA:
  - Shift out the TX byte; if TX was empty, send 0xFF.
  - Release sda for the 9th bit and sample the master ACK at scl rising edge.
  - ACK (0): pop next and continue. NACK (1): go to WAIT_STOP.
- sda_o is released on the scl falling edge that ends each ACK slot.
- EN=0 forces IDLE and sda_o=1; FIFOs keep their contents.
- Simultaneous Wishbone pop and I2C push on the RX FIFO are both honoured; the same holds for TX.

Optional Feature:
- I2C_GEN_CALL_EN defined: address byte 0x00 (general call, write) is ACKed and treated as a write to this slave.
- Undefined: 0x00 never matches unless ADDR=0.

Decomposition:
- Shared package i2c_wb_slave_pkg holds:
  - register offset constants (CSR=0, ADDR=1, RXDATA=2, TXDATA=3)
  - CSR bit-index constants
  - the FSM state enum
- One sub-module, byte_fifo (parameterized depth, push, pop, full, empty, dout), instantiated for RX and TX.

Test Plan:
- Reset then read regs: CSR=0x02 (TX_EMPTY), ADDR=0x22, irq=0, sda_o=1.
- Set CSR=0xC0. I2C master writes 0x44 then bytes 0x00..0x1F (32 bytes) then STOP:
  - 16 ACKs, then NACK on byte 16.
  - RXDATA reads return 0x00..0x0F.
  - STOP_SEEN=1 and irq=1.
- Push 0x64..0x67 to TXDATA. Master reads 5 bytes from 0x45, NACKing the last:
  - master sees 0x64, 0x65, 0x66, 0x67, 0xFF
  - LAST_RD=1
- Address 0x30 (mismatch): NACK, sda stays released through STOP, RX stays empty.
- Write 0x44, byte 0xAA, repeated START, 0x45, read 1 byte with NACK:
  - RX holds 0xAA; read returns the TX head.
  - BUSY=1 until STOP.
- Assert rst_i mid-byte: sda_o=1 and FSM IDLE immediately; the next START/address is handled normally.

Source files
------------

// File: rtl/i2c_wb_slave_pkg.sv
// Shared definitions for the I2C slave port: register map, CSR bit positions and FSM states.
package i2c_wb_slave_pkg;

  localparam logic [1:0] REG_CSR    = 2'd0;
  localparam logic [1:0] REG_ADDR   = 2'd1;
  localparam logic [1:0] REG_RXDATA = 2'd2;
  localparam logic [1:0] REG_TXDATA = 2'd3;

  localparam int CSR_EN          = 7;
  localparam int CSR_IE          = 6;
  localparam int CSR_STOP_SEEN   = 4;
  localparam int CSR_LAST_RD     = 3;
  localparam int CSR_BUSY        = 2;
  localparam int CSR_TX_EMPTY    = 1;
  localparam int CSR_RX_NONEMPTY = 0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_WR_DATA   = 3'd3,
    ST_WR_ACK    = 3'd4,
    ST_RD_DATA   = 3'd5,
    ST_RD_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } i2c_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO or a pop from an empty one is ignored.
module byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/i2c_wb_slave_port.sv
// I2C slave responder with a Wishbone classic register port and RX/TX byte FIFOs.
// Define I2C_GEN_CALL_EN to also ACK the general-call address 0x00 as a write.
module i2c_wb_slave_port
  import i2c_wb_slave_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR   = 7'h22,
  parameter int         FIFO_DEPTH = 16,
  parameter int         WB_ADDR    = 2,
  parameter int         WB_DATA    = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cyc_i,
  input  logic               stb_i,
  input  logic               we_i,
  input  logic [WB_ADDR-1:0] adr_i,
  input  logic [WB_DATA-1:0] dat_i,
  output logic [WB_DATA-1:0] dat_o,
  output logic               ack_o,
  output logic               irq,
  input  logic               scl_i,
  input  logic               sda_i,
  output logic               sda_o,
  output logic [2:0]         fsm_state
);

  i2c_state_e state;
  logic [2:0] scl_sync, sda_sync;
  logic       scl_s, scl_d, sda_s, sda_d;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic       en, ie, stop_seen, last_rd, busy, rw;
  logic [6:0] addr_reg;
  logic [3:0] bit_cnt;
  logic [7:0] sh;
  logic [6:0] tx_sh;
  logic [7:0] tx_byte, rd_val;
  logic [1:0] reg_sel;
  logic       wb_req, rx_pop, tx_push, rx_push_q, tx_pop_q;
  logic [7:0] rx_dout, tx_dout;
  logic       rx_full, rx_empty, tx_full, tx_empty;

  function automatic logic addr_match(input logic [7:0] b, input logic [6:0] a);
`ifdef I2C_GEN_CALL_EN
    return (b[7:1] == a) || (b == 8'h00);
`else
    return (b[7:1] == a);
`endif
  endfunction

  assign scl_s     = scl_sync[1];
  assign scl_d     = scl_sync[2];
  assign sda_s     = sda_sync[1];
  assign sda_d     = sda_sync[2];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = en & scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = en & scl_s & scl_d & ~sda_d & sda_s;
  assign tx_byte   = tx_empty ? 8'hFF : tx_dout;
  assign fsm_state = 3'(state);

  // Wishbone: a request is cyc_i & stb_i while ack_o is low; ack_o answers it for exactly
  // one cycle, with dat_o valid and any write/push/pop taking effect on that same edge.
  assign reg_sel = adr_i[1:0];
  assign wb_req  = cyc_i & stb_i & ~ack_o;
  assign rx_pop  = wb_req & ~we_i & (reg_sel == REG_RXDATA) & ~rx_empty;
  assign tx_push = wb_req & we_i & (reg_sel == REG_TXDATA) & ~tx_full;

  always_comb begin
    rd_val = 8'h00;
    case (reg_sel)
      REG_CSR: begin
        rd_val[CSR_EN]          = en;
        rd_val[CSR_IE]          = ie;
        rd_val[CSR_STOP_SEEN]   = stop_seen;
        rd_val[CSR_LAST_RD]     = last_rd;
        rd_val[CSR_BUSY]        = busy;
        rd_val[CSR_TX_EMPTY]    = tx_empty;
        rd_val[CSR_RX_NONEMPTY] = ~rx_empty;
      end
      REG_ADDR:   rd_val = {1'b0, addr_reg};
      REG_RXDATA: rd_val = rx_empty ? 8'h00 : rx_dout;
      default:    rd_val = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_o     <= 1'b0;
      dat_o     <= '0;
      irq       <= 1'b0;
      en        <= 1'b0;
      ie        <= 1'b0;
      stop_seen <= 1'b0;
      addr_reg  <= I2C_ADDR;
    end else begin
      ack_o <= wb_req;
      irq   <= ie & (~rx_empty | stop_seen);
      if (wb_req) begin
        if (we_i) begin
          if (reg_sel == REG_CSR) begin
            en <= dat_i[CSR_EN];
            ie <= dat_i[CSR_IE];
            if (dat_i[CSR_STOP_SEEN]) stop_seen <= 1'b0;
          end else if (reg_sel == REG_ADDR) begin
            addr_reg <= dat_i[6:0];
          end
        end else begin
          dat_o <= WB_DATA'(rd_val);
        end
      end
      if (stop_det) stop_seen <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_sync <= 3'b111;
      sda_sync <= 3'b111;
    end else begin
      scl_sync <= {scl_sync[1:0], scl_i};
      sda_sync <= {sda_sync[1:0], sda_i};
    end
  end

  // In the ACK states bit_cnt only tells the first scl fall (drive ACK) from the second (release).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      sda_o     <= 1'b1;
      bit_cnt   <= '0;
      sh        <= '0;
      tx_sh     <= '0;
      rw        <= 1'b0;
      last_rd   <= 1'b0;
      busy      <= 1'b0;
      rx_push_q <= 1'b0;
      tx_pop_q  <= 1'b0;
    end else begin
      rx_push_q <= 1'b0;
      tx_pop_q  <= 1'b0;
      if (!en) begin
        state   <= ST_IDLE;
        sda_o   <= 1'b1;
        bit_cnt <= '0;
        busy    <= 1'b0;
      end else if (stop_det) begin
        state <= ST_IDLE;
        sda_o <= 1'b1;
        busy  <= 1'b0;
      end else if (start_det) begin
        state   <= ST_ADDR;
        sda_o   <= 1'b1;
        bit_cnt <= '0;
        busy    <= 1'b1;
      end else begin
        case (state)
          ST_ADDR: if (scl_rise) begin
            sh <= {sh[6:0], sda_s};
            if (bit_cnt == 4'd7) begin
              bit_cnt <= '0;
              if (addr_match({sh[6:0], sda_s}, addr_reg)) begin
                rw      <= sda_s;
                last_rd <= sda_s;
                state   <= ST_ADDR_ACK;
              end else begin
                state <= ST_WAIT_STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          ST_ADDR_ACK: if (scl_fall) begin
            if (bit_cnt == 4'd0) begin
              sda_o   <= 1'b0;
              bit_cnt <= 4'd1;
            end else begin
              bit_cnt <= '0;
              if (rw) begin
                sda_o    <= tx_byte[7];
                tx_sh    <= tx_byte[6:0];
                tx_pop_q <= ~tx_empty;
                state    <= ST_RD_DATA;
              end else begin
                sda_o <= 1'b1;
                state <= ST_WR_DATA;
              end
            end
          end
          ST_WR_DATA: if (scl_rise) begin
            sh <= {sh[6:0], sda_s};
            if (bit_cnt == 4'd7) begin
              bit_cnt <= '0;
              if (rx_full) begin
                state <= ST_WAIT_STOP;
              end else begin
                rx_push_q <= 1'b1;
                state     <= ST_WR_ACK;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          ST_WR_ACK: if (scl_fall) begin
            if (bit_cnt == 4'd0) begin
              sda_o   <= 1'b0;
              bit_cnt <= 4'd1;
            end else begin
              sda_o   <= 1'b1;
              bit_cnt <= '0;
              state   <= ST_WR_DATA;
            end
          end
          ST_RD_DATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_o   <= 1'b1;
                bit_cnt <= '0;
                state   <= ST_RD_ACK;
              end else begin
                sda_o <= tx_sh[6];
                tx_sh <= {tx_sh[5:0], 1'b0};
              end
            end
          end
          ST_RD_ACK: begin
            if (scl_rise) begin
              sh      <= {sh[6:0], sda_s};
              bit_cnt <= 4'd1;
            end else if (scl_fall && bit_cnt == 4'd1) begin
              bit_cnt <= '0;
              if (!sh[0]) begin
                sda_o    <= tx_byte[7];
                tx_sh    <= tx_byte[6:0];
                tx_pop_q <= ~tx_empty;
                state    <= ST_RD_DATA;
              end else begin
                state <= ST_WAIT_STOP;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (rx_push_q),
    .din   (sh),
    .pop   (rx_pop),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (tx_push),
    .din   (dat_i[7:0]),
    .pop   (tx_pop_q),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty)
  );

endmodule

// File: tb/tb_i2c_wb_slave_port.sv
// Bench for i2c_wb_slave_port: the bench is the I2C master and the Wishbone host, checked
// against a transaction-level model of the register map and the two byte queues.
module tb_i2c_wb_slave_port;
  import i2c_wb_slave_pkg::*;

  localparam int Q = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [1:0] adr = 2'd0;
  logic [7:0] dat_w = 8'h00;
  logic [7:0] dat_r;
  logic       ack, irq, sda_o;
  logic       scl_m = 1'b1, sda_m = 1'b1;
  logic       sda_line;
  logic [2:0] fsm_state;
  logic       watch = 1'b0, low_seen = 1'b0;

  assign sda_line = sda_m & sda_o;

  always #5 clk = ~clk;

  always @(negedge clk) if (watch && sda_o == 1'b0) low_seen = 1'b1;

  i2c_wb_slave_port dut (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we),
    .adr_i(adr), .dat_i(dat_w), .dat_o(dat_r), .ack_o(ack), .irq(irq),
    .scl_i(scl_m), .sda_i(sda_line), .sda_o(sda_o), .fsm_state(fsm_state)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic [6:0] m_addr = 7'h22;
  logic       m_en = 0, m_ie = 0, m_stop = 0, m_busy = 0, m_last_rd = 0;
  int         m_mode = 0; // 0 ignoring, 1 expecting address, 2 write, 3 read

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] m_csr();
    return {m_en, m_ie, 1'b0, m_stop, m_last_rd, m_busy,
            logic'(tx_q.size() == 0), logic'(rx_q.size() != 0)};
  endfunction

  function automatic logic m_match(input logic [7:0] b);
`ifdef I2C_GEN_CALL_EN
    return (b[7:1] == m_addr) || (b == 8'h00);
`else
    return (b[7:1] == m_addr);
`endif
  endfunction

  task automatic model_reset();
    rx_q.delete();
    tx_q.delete();
    m_addr = 7'h22; m_en = 0; m_ie = 0; m_stop = 0; m_busy = 0; m_last_rd = 0; m_mode = 0;
  endtask

  task automatic wb_cycle(input logic w, input logic [1:0] a, input logic [7:0] d,
                          output logic [7:0] q);
    int n;
    n = 0;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d;
    do begin
      tick(1);
      n++;
    end while (!ack && n < 8);
    chk("wb_ack", ack, 1'b1);
    q = dat_r;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick(1);
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [7:0] d);
    logic [7:0] q;
    wb_cycle(1'b1, a, d, q);
    case (a)
      REG_CSR: begin
        m_en = d[7]; m_ie = d[6];
        if (d[4]) m_stop = 1'b0;
      end
      REG_ADDR: m_addr = d[6:0];
      REG_TXDATA: if (tx_q.size() < 16) tx_q.push_back(d);
      default: ;
    endcase
  endtask

  task automatic check_reg(input string tag, input logic [1:0] a);
    logic [7:0] exp, q;
    case (a)
      REG_CSR:    exp = m_csr();
      REG_ADDR:   exp = {1'b0, m_addr};
      REG_RXDATA: exp = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
      default:    exp = 8'h00;
    endcase
    wb_cycle(1'b0, a, 8'h00, q);
    chk(tag, q, exp);
  endtask

  task automatic check_irq();
    tick(2);
    chk("irq", irq, m_ie & (m_stop | (rx_q.size() != 0)));
  endtask

  task automatic i2c_bit(input logic b, output logic s);
    sda_m = b;
    tick(Q);
    scl_m = 1'b1;
    tick(Q);
    s = sda_line;
    tick(Q);
    scl_m = 1'b0;
    tick(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
    if (m_en) begin m_busy = 1'b1; m_mode = 1; end
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
    if (m_en) begin m_busy = 1'b0; m_stop = 1'b1; m_mode = 0; end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) i2c_bit(b[i], s);
    i2c_bit(1'b1, s);
    acked = ~s;
  endtask

  task automatic do_addr(input logic [7:0] b);
    logic acked, exp;
    exp = (m_mode == 1) && m_match(b);
    send_byte(b, acked);
    chk("addr_ack", acked, exp);
    if (exp) begin m_mode = b[0] ? 3 : 2; m_last_rd = b[0]; end
    else m_mode = 0;
  endtask

  task automatic do_wr(input logic [7:0] b);
    logic acked, exp;
    exp = (m_mode == 2) && (rx_q.size() < 16);
    send_byte(b, acked);
    chk("wr_ack", acked, exp);
    if (exp) rx_q.push_back(b);
    else m_mode = 0;
  endtask

  task automatic do_rd(input logic nack);
    logic [7:0] exp, got;
    logic s;
    exp = 8'hFF;
    if (m_mode == 3 && tx_q.size() != 0) exp = tx_q.pop_front();
    got = 8'h00;
    for (int i = 0; i < 8; i++) begin
      i2c_bit(1'b1, s);
      got = {got[6:0], s};
    end
    i2c_bit(nack, s);
    chk("rd_data", got, exp);
    if (nack) m_mode = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b, ab;
    logic       s;
    int         n, k;

    tick(3);
    rst = 1'b0;
    tick(2);
    check_reg("reset_csr", REG_CSR);
    check_reg("reset_addr", REG_ADDR);
    chk("reset_irq", irq, 1'b0);
    chk("reset_sda", sda_o, 1'b1);
    chk("reset_state", fsm_state, 3'(ST_IDLE));

    // Write burst that overflows the RX FIFO
    wb_write(REG_CSR, 8'hC0);
    i2c_start();
    do_addr(8'h44);
    for (int i = 0; i < 32; i++) do_wr(8'(i));
    i2c_stop();
    check_reg("csr_after_wr", REG_CSR);
    check_irq();
    for (int i = 0; i < 16; i++) check_reg("rxdata", REG_RXDATA);
    check_reg("rxdata_empty", REG_RXDATA);
    wb_write(REG_CSR, 8'hD0);
    check_reg("csr_cleared", REG_CSR);
    check_irq();

    // Read 5 bytes with only 4 preloaded
    for (int i = 0; i < 4; i++) wb_write(REG_TXDATA, 8'h64 + 8'(i));
    i2c_start();
    do_addr(8'h45);
    for (int i = 0; i < 4; i++) do_rd(1'b0);
    do_rd(1'b1);
    i2c_stop();
    check_reg("csr_after_rd", REG_CSR);

    // Address mismatch: slave must never pull sda
    wb_write(REG_CSR, 8'hD0);
    low_seen = 1'b0;
    watch = 1'b1;
    i2c_start();
    do_addr(8'h30);
    do_wr(8'h55);
    i2c_stop();
    watch = 1'b0;
    chk("mismatch_sda_low", low_seen, 1'b0);
    check_reg("csr_mismatch", REG_CSR);

    // Write, repeated start, read
    wb_write(REG_CSR, 8'hD0);
    wb_write(REG_TXDATA, 8'h5A);
    i2c_start();
    do_addr(8'h44);
    do_wr(8'hAA);
    check_reg("csr_busy_wr", REG_CSR);
    i2c_start();
    do_addr(8'h45);
    do_rd(1'b1);
    check_reg("csr_busy_rd", REG_CSR);
    i2c_stop();
    check_reg("csr_after_rs", REG_CSR);
    check_reg("rxdata_rs", REG_RXDATA);

    // Reset while the slave is driving the address ACK
    wb_write(REG_CSR, 8'hD0);
    i2c_start();
    b = 8'h44;
    for (int i = 7; i >= 0; i--) i2c_bit(b[i], s);
    chk("ack_driven", sda_o, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_sda", sda_o, 1'b1);
    chk("rst_state", fsm_state, 3'(ST_IDLE));
    tick(2);
    rst = 1'b0;
    model_reset();
    tick(2);
    check_reg("csr_post_rst", REG_CSR);
    wb_write(REG_CSR, 8'hC0);
    i2c_stop();
    i2c_start();
    do_addr(8'h44);
    do_wr(8'h3C);
    i2c_stop();
    check_reg("csr_post_rst_wr", REG_CSR);
    check_reg("rxdata_post_rst", REG_RXDATA);

    // Randomized transactions
    for (int it = 0; it < 6; it++) begin
      wb_write(REG_CSR, 8'hD0);
      if ($urandom_range(0, 3) == 0) wb_write(REG_ADDR, 8'($urandom_range(1, 127)));
      ab = {m_addr, 1'($urandom_range(0, 1))};
      if ($urandom_range(0, 4) == 0) ab = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 20);
      if (!ab[0]) begin
        i2c_start();
        do_addr(ab);
        for (int i = 0; i < n; i++) do_wr(8'($urandom_range(0, 255)));
      end else begin
        k = $urandom_range(0, 18);
        for (int i = 0; i < k; i++) wb_write(REG_TXDATA, 8'($urandom_range(0, 255)));
        i2c_start();
        do_addr(ab);
        for (int i = 1; i < n; i++) do_rd(1'b0);
        do_rd(1'b1);
      end
      i2c_stop();
      check_reg("rand_csr", REG_CSR);
      check_irq();
      while (rx_q.size() != 0) check_reg("rand_rxdata", REG_RXDATA);
      check_reg("rand_rx_empty", REG_RXDATA);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
